// File: rtl/cpu_bus_sequencer_pkg.sv
// Shared types for the W65C02S bus-slot sequencer: CPU speed selector and
// the pacing period it implies at a given system clock.
package cpu_bus_sequencer_pkg;

    typedef enum logic [1:0] {
        CPU_SPEED_1MHZ = 2'd0,
        CPU_SPEED_2MHZ = 2'd1,
        CPU_SPEED_4MHZ = 2'd2,
        CPU_SPEED_MAX  = 2'd3
    } cpu_speed_t;

    // MAX paces every cycle; the pacer treats it as a period of one.
    function automatic int cpu_speed_period(cpu_speed_t speed, int mhz);
        case (speed)
            CPU_SPEED_1MHZ: return mhz;
            CPU_SPEED_2MHZ: return mhz / 2;
            CPU_SPEED_4MHZ: return mhz / 4;
            default:        return 1;
        endcase
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu_bus_sequencer_if.sv
// Request/grant handshake and CPU pin bundle; master is the sequencer,
// slave is the arbiter/CPU side.
interface cpu_bus_sequencer_if;
    import cpu_bus_sequencer_pkg::*;

    logic       cpu_enable_i;
    cpu_speed_t cpu_speed_i;
    logic       cpu_grant_i;
    logic       cpu_wait_i;
    logic       cpu_req_o;
    logic       cpu_be_o;
    logic       cpu_clock_o;
    logic       cpu_valid_strobe_o;
    logic       cpu_done_strobe_o;
    logic       cpu_overrun_strobe_o;
    logic       cpu_wait_timeout_strobe_o;

    modport master (
        input  cpu_enable_i, cpu_speed_i, cpu_grant_i, cpu_wait_i,
        output cpu_req_o, cpu_be_o, cpu_clock_o, cpu_valid_strobe_o,
               cpu_done_strobe_o, cpu_overrun_strobe_o, cpu_wait_timeout_strobe_o
    );

    modport slave (
        output cpu_enable_i, cpu_speed_i, cpu_grant_i, cpu_wait_i,
        input  cpu_req_o, cpu_be_o, cpu_clock_o, cpu_valid_strobe_o,
               cpu_done_strobe_o, cpu_overrun_strobe_o, cpu_wait_timeout_strobe_o
    );

endinterface

// File: rtl/cpu_bus_sequencer_pacer.sv
// CPU cycle pacer: period counter, single-deep pending request latch and
// overrun strobe.
module cpu_bus_sequencer_pacer
    import cpu_bus_sequencer_pkg::*;
#(
    parameter int SYS_CLOCK_MHZ = 64
) (
    input  logic       sys_clock_i,
    input  logic       sys_reset_i,
    input  logic       enable,
    input  cpu_speed_t speed,
    input  logic       idle,
    input  logic       accept,
    output logic       pending,
    output logic       overrun
);

    localparam int CW = $clog2(SYS_CLOCK_MHZ) + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    logic          primed;
    logic          expire;
    logic          max_mode;
    cpu_speed_t    cur_speed;
    cpu_speed_t    eff_speed;

    // Until the first reload the live selector defines the period, so the
    // first request lands one full period after reset release.
    assign eff_speed = primed ? cur_speed : speed;
    assign limit     = CW'(cpu_speed_period(eff_speed, SYS_CLOCK_MHZ) - 1);
    assign expire    = (cnt >= limit);
    assign max_mode  = (eff_speed == CPU_SPEED_MAX);

    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            cnt       <= '0;
            primed    <= 1'b0;
            cur_speed <= CPU_SPEED_1MHZ;
            pending   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (expire) begin
                cnt       <= '0;
                cur_speed <= speed;
                primed    <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // An expiry coinciding with an accepted grant re-arms pending
            // without counting as an overrun.
            if (max_mode)
                pending <= !accept && (pending || (idle && enable));
            else if (expire && enable) begin
                pending <= 1'b1;
                overrun <= pending && !accept;
            end else if (accept)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// W65C02S bus-slot sequencer: paces CPU cycles, requests a slot and drives
// BE/Phi2 through drain/setup/pulse/hold once granted.
module cpu_bus_sequencer
    import cpu_bus_sequencer_pkg::*;
#(
    parameter int SYS_CLOCK_MHZ   = 64,
    parameter int DRAIN_CYCLES    = 1,
    parameter int VALID_OFFSET    = 3,
    parameter int BE_SETUP_CYCLES = 4,
    parameter int PHI_HIGH_CYCLES = 4,
    parameter int HOLD_CYCLES     = 4,
    parameter int MAX_WAIT_CYCLES = 16
) (
    input  logic                sys_clock_i,
    input  logic                sys_reset_i,
    cpu_bus_sequencer_if.master bus
);

    localparam int CNT_MAX = max_int(max_int(DRAIN_CYCLES, BE_SETUP_CYCLES),
                                     max_int(HOLD_CYCLES, PHI_HIGH_CYCLES + MAX_WAIT_CYCLES));
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(BE_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] VALID_AT   = CW'(VALID_OFFSET);
    localparam logic [CW-1:0] PHI_LAST   = CW'(PHI_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] PHI_CAP    = CW'(PHI_HIGH_CYCLES + MAX_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_PHI   = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          timeout_nxt;
    logic          idle, accept, pending, overrun;
    logic          be_q, phi_q, valid_q, done_q, timeout_q;

    assign idle   = (state == ST_IDLE);
    assign accept = bus.cpu_grant_i && idle && pending;

    cpu_bus_sequencer_pacer #(
        .SYS_CLOCK_MHZ (SYS_CLOCK_MHZ)
    ) u_pacer (
        .sys_clock_i (sys_clock_i),
        .sys_reset_i (sys_reset_i),
        .enable      (bus.cpu_enable_i),
        .speed       (bus.cpu_speed_i),
        .idle        (idle),
        .accept      (accept),
        .pending     (pending),
        .overrun     (overrun)
    );

    // cnt counts up within a phase; in PHI it keeps counting through the
    // stretch, so PHI_CAP bounds the total Phi2 high time.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = ST_DRAIN;
            end
            ST_DRAIN:
                if (cnt == DRAIN_LAST) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = '0;
                end
            ST_SETUP:
                if (cnt == SETUP_LAST) begin
                    state_nxt = ST_PHI;
                    cnt_nxt   = '0;
                end
            ST_PHI:
                if (cnt >= PHI_LAST) begin
                    if (!bus.cpu_wait_i || cnt == PHI_CAP) begin
                        timeout_nxt = bus.cpu_wait_i;
                        state_nxt   = ST_HOLD;
                        cnt_nxt     = '0;
                    end
                end
            ST_HOLD:
                if (cnt == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they change on the same
    // edge as the state they belong to.
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            be_q      <= 1'b0;
            phi_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            be_q      <= (state_nxt == ST_SETUP) || (state_nxt == ST_PHI) ||
                         (state_nxt == ST_HOLD);
            phi_q     <= (state_nxt == ST_PHI);
            valid_q   <= (state_nxt == ST_SETUP) && (cnt_nxt == VALID_AT);
            done_q    <= (state_nxt == ST_HOLD) && (cnt_nxt == HOLD_LAST);
            timeout_q <= timeout_nxt;
        end
    end

    assign bus.cpu_req_o                 = pending;
    assign bus.cpu_be_o                  = be_q;
    assign bus.cpu_clock_o               = phi_q;
    assign bus.cpu_valid_strobe_o        = valid_q;
    assign bus.cpu_done_strobe_o         = done_q;
    assign bus.cpu_overrun_strobe_o      = overrun;
    assign bus.cpu_wait_timeout_strobe_o = timeout_q;

endmodule
